// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, select codes,
// FSM states and the decoded instruction class.
package mc_pkg;

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpOri     = 6'b001101;
  localparam logic [5:0] OpLui     = 6'b001111;
  localparam logic [5:0] OpLw      = 6'b100011;
  localparam logic [5:0] OpSw      = 6'b101011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;

  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnNop  = 6'b000000;

  typedef enum logic [2:0] {AluAdd = 3'd0, AluSub = 3'd1, AluAnd = 3'd2, AluOr = 3'd3} alu_op_e;
  typedef enum logic [1:0] {NpcPc4, NpcBranch, NpcJump, NpcJr} npc_sel_e;
  typedef enum logic [1:0] {DstRt, DstRd, DstRa} reg_dst_e;
  typedef enum logic [1:0] {WbAlu, WbMem, WbPc4} mem_to_reg_e;
  typedef enum logic [1:0] {ExtZero, ExtSign, ExtLui} ext_op_e;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

  // One-hot instruction class; all-zero means undecoded.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } instr_cls_t;

endpackage

// File: rtl/mc_decoder.sv
// Combinational opcode/funct decode into a one-hot instruction class.
module mc_decoder
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output instr_cls_t cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OpSpecial: begin
        case (funct_i)
          FnAddu:  cls_o.addu = 1'b1;
          FnSubu:  cls_o.subu = 1'b1;
          FnJr:    cls_o.jr   = 1'b1;
          FnNop:   cls_o.nop  = 1'b1;
          default: ;
        endcase
      end
      OpOri:   cls_o.ori = 1'b1;
      OpLui:   cls_o.lui = 1'b1;
      OpLw:    cls_o.lw  = 1'b1;
      OpSw:    cls_o.sw  = 1'b1;
      OpBeq:   cls_o.beq = 1'b1;
      OpJ:     cls_o.j   = 1'b1;
      OpJal:   cls_o.jal = 1'b1;
      default: ;
    endcase
    illegal_o = (cls_o == '0);
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: one datapath phase per cycle, strobes from
// state plus decoded class, selects straight from the decoded class.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             alu_zero_i,
  input  logic             mem_ready_i,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic [1:0]       npc_sel_o,
  output logic             reg_we_o,
  output logic [1:0]       reg_dst_o,
  output logic [1:0]       mem_to_reg_o,
  output logic             mem_we_o,
  output logic [2:0]       alu_op_o,
  output logic             alu_src_o,
  output logic [1:0]       ext_op_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  instr_cls_t       cls;
  logic             dec_illegal;
  logic             ir_we, pc_we, reg_we, mem_we, illegal;
  npc_sel_e         npc_sel;
  reg_dst_e         reg_dst;
  mem_to_reg_e      mem_to_reg;
  alu_op_e          alu_op;
  ext_op_e          ext_op;

  mc_decoder u_decoder (
    .opcode_i  (opcode_i),
    .funct_i   (funct_i),
    .cls_o     (cls),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      StFetch: begin
        ir_we   = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        if (dec_illegal) begin
          // Undecoded words retire as nops so the core keeps running.
          illegal = 1'b1;
          pc_we   = 1'b1;
          state_d = StFetch;
        end else if (cls.j || cls.jal || cls.jr || cls.nop) begin
          pc_we   = 1'b1;
          reg_we  = cls.jal;
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (cls.beq) begin
          pc_we   = 1'b1;
          state_d = StFetch;
        end else if (cls.lw || cls.sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_we = cls.sw;
        if (mem_ready_i) begin
          if (cls.sw) begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Selects depend only on the instruction, so ALU controls stay held from EXEC onwards.
  always_comb begin
    npc_sel = NpcPc4;
    if (cls.j || cls.jal) begin
      npc_sel = NpcJump;
    end else if (cls.jr) begin
      npc_sel = NpcJr;
    end else if (cls.beq && alu_zero_i) begin
      npc_sel = NpcBranch;
    end

    reg_dst = DstRt;
    if (cls.jal) begin
      reg_dst = DstRa;
    end else if (cls.addu || cls.subu) begin
      reg_dst = DstRd;
    end

    mem_to_reg = WbAlu;
    if (cls.jal) begin
      mem_to_reg = WbPc4;
    end else if (cls.lw) begin
      mem_to_reg = WbMem;
    end

    alu_op = AluAdd;
    if (cls.subu || cls.beq) begin
      alu_op = AluSub;
    end else if (cls.ori || cls.lui) begin
      alu_op = AluOr;
    end

    ext_op = ExtZero;
    if (cls.lui) begin
      ext_op = ExtLui;
    end else if (cls.lw || cls.sw) begin
      ext_op = ExtSign;
    end
  end

  assign retired_d = pc_we ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Reset gates the strobes so nothing writes while reset is low.
  assign ir_we_o      = ir_we & rst_ni;
  assign pc_we_o      = pc_we & rst_ni;
  assign reg_we_o     = reg_we & rst_ni;
  assign mem_we_o     = mem_we & rst_ni;
  assign illegal_o    = illegal & rst_ni;
  assign npc_sel_o    = npc_sel;
  assign reg_dst_o    = reg_dst;
  assign mem_to_reg_o = mem_to_reg;
  assign alu_op_o     = alu_op;
  assign alu_src_o    = cls.ori | cls.lui | cls.lw | cls.sw;
  assign ext_op_o     = ext_op;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction expectations are queued
// by the driver and checked by a monitor at each pc_we (instruction completion).
module tb_mc_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode, funct;
  logic          alu_zero, mem_ready;
  logic          ir_we, pc_we, reg_we, mem_we, alu_src, illegal;
  logic [1:0]    npc_sel, reg_dst, mem_to_reg, ext_op;
  logic [2:0]    alu_op;
  logic [CW-1:0] retired;

  mc_controller #(.CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .opcode_i     (opcode),
    .funct_i      (funct),
    .alu_zero_i   (alu_zero),
    .mem_ready_i  (mem_ready),
    .ir_we_o      (ir_we),
    .pc_we_o      (pc_we),
    .npc_sel_o    (npc_sel),
    .reg_we_o     (reg_we),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .mem_we_o     (mem_we),
    .alu_op_o     (alu_op),
    .alu_src_o    (alu_src),
    .ext_op_o     (ext_op),
    .illegal_o    (illegal),
    .retired_o    (retired)
  );

  always #5 clk = ~clk;

  typedef enum int {KAddu, KSubu, KOri, KLui, KLw, KSw, KBeq, KJ, KJal, KJr, KNop, KIll} kind_e;

  typedef struct packed {
    int            cycles;
    logic [1:0]    npc;
    int            n_reg;
    logic [1:0]    dst;
    logic [1:0]    m2r;
    int            n_mem;
    int            n_ill;
    logic          chk_alu;
    logic [2:0]    aop;
    logic          asrc;
    logic          chk_ext;
    logic [1:0]    ext;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          sbq[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] model_ret = '0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour per instruction: cycle count, strobe counts and selects.
  function automatic exp_t model(input kind_e k, input logic z, input int w,
                                 input logic [CW-1:0] ret);
    exp_t e;
    e = '0;
    e.ret = ret;
    case (k)
      KAddu: begin e.cycles = 4; e.n_reg = 1; e.dst = 1; e.chk_alu = 1; e.aop = 0; end
      KSubu: begin e.cycles = 4; e.n_reg = 1; e.dst = 1; e.chk_alu = 1; e.aop = 1; end
      KOri: begin
        e.cycles = 4; e.n_reg = 1; e.chk_alu = 1; e.aop = 3; e.asrc = 1;
        e.chk_ext = 1; e.ext = 0;
      end
      KLui: begin
        e.cycles = 4; e.n_reg = 1; e.chk_alu = 1; e.aop = 3; e.asrc = 1;
        e.chk_ext = 1; e.ext = 2;
      end
      KLw: begin
        e.cycles = 5 + w; e.n_reg = 1; e.m2r = 1; e.chk_alu = 1; e.aop = 0; e.asrc = 1;
        e.chk_ext = 1; e.ext = 1;
      end
      KSw: begin
        e.cycles = 4 + w; e.n_mem = w + 1; e.chk_alu = 1; e.aop = 0; e.asrc = 1;
        e.chk_ext = 1; e.ext = 1;
      end
      KBeq: begin e.cycles = 3; e.npc = z ? 2'd1 : 2'd0; e.chk_alu = 1; e.aop = 1; end
      KJ:   begin e.cycles = 2; e.npc = 2; end
      KJal: begin e.cycles = 2; e.npc = 2; e.n_reg = 1; e.dst = 2; e.m2r = 2; end
      KJr:  begin e.cycles = 2; e.npc = 3; end
      KNop: e.cycles = 2;
      default: begin e.cycles = 2; e.n_ill = 1; end
    endcase
    return e;
  endfunction

  task automatic encode(input kind_e k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom_range(0, 63));
    case (k)
      KAddu: begin op = 6'h00; fn = 6'h21; end
      KSubu: begin op = 6'h00; fn = 6'h23; end
      KJr:   begin op = 6'h00; fn = 6'h08; end
      KNop:  begin op = 6'h00; fn = 6'h00; end
      KOri:  op = 6'h0d;
      KLui:  op = 6'h0f;
      KLw:   op = 6'h23;
      KSw:   op = 6'h2b;
      KBeq:  op = 6'h04;
      KJ:    op = 6'h02;
      KJal:  op = 6'h03;
      default: begin
        case ($urandom_range(0, 2))
          0:       op = 6'h3f;
          1:       op = 6'h08;
          default: begin op = 6'h00; fn = 6'h20; end
        endcase
      end
    endcase
  endtask

  // Monitor: accumulate per-instruction activity, compare at each completion.
  int         m_cyc = 0, m_ir = 0, m_reg = 0, m_mem = 0, m_ill = 0;
  logic [1:0] m_dst, m_m2r;
  exp_t       e_mon;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      check("reset_strobes", {ir_we, pc_we, reg_we, mem_we, illegal}, 0);
      check("reset_retired", retired, 0);
      m_cyc = 0; m_ir = 0; m_reg = 0; m_mem = 0; m_ill = 0;
    end else begin
      m_cyc++;
      if (ir_we) m_ir++;
      if (reg_we) begin
        m_reg++;
        m_dst = reg_dst;
        m_m2r = mem_to_reg;
      end
      if (mem_we) m_mem++;
      if (illegal) m_ill++;
      if (reg_we || mem_we) check("reg_mem_exclusive", reg_we & mem_we, 0);
      if (pc_we) begin
        if (sbq.size() == 0) begin
          check("unexpected_pc_we", pc_we, 0);
        end else begin
          e_mon = sbq.pop_front();
          check("cycles", m_cyc, e_mon.cycles);
          check("ir_we_count", m_ir, 1);
          check("npc_sel", npc_sel, e_mon.npc);
          check("reg_we_count", m_reg, e_mon.n_reg);
          check("mem_we_count", m_mem, e_mon.n_mem);
          check("illegal_count", m_ill, e_mon.n_ill);
          check("retired", retired, e_mon.ret);
          if (e_mon.n_reg != 0) begin
            check("reg_dst", m_dst, e_mon.dst);
            check("mem_to_reg", m_m2r, e_mon.m2r);
          end
          if (e_mon.chk_alu) begin
            check("alu_op", alu_op, e_mon.aop);
            check("alu_src", alu_src, e_mon.asrc);
          end
          if (e_mon.chk_ext) check("ext_op", ext_op, e_mon.ext);
        end
        m_cyc = 0; m_ir = 0; m_reg = 0; m_mem = 0; m_ill = 0;
      end
    end
  end

  // Called at a negedge in FETCH; returns at the negedge of the next FETCH.
  task automatic run_instr(input kind_e k, input logic z, input int w);
    logic [5:0] op, fn;
    int c;
    encode(k, op, fn);
    opcode   = op;
    funct    = fn;
    alu_zero = z;
    sbq.push_back(model(k, z, w, model_ret));
    model_ret = model_ret + 1'b1;
    c = 0;
    mem_ready = 1'b0;
    do begin
      @(negedge clk);
      c++;
      mem_ready = (c >= 3 + w);
    end while (!ir_we && c < 40);
    if (c >= 40) check("instr_timeout_ir_we", ir_we, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = '0;
    funct = '0;
    alu_zero = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ir_we_after_reset", ir_we, 1);

    run_instr(KAddu, 1'b0, 0);
    run_instr(KBeq, 1'b1, 0);
    run_instr(KBeq, 1'b0, 0);
    run_instr(KLw, 1'b0, 2);
    run_instr(KSw, 1'b0, 2);
    run_instr(KJal, 1'b0, 0);
    run_instr(KIll, 1'b0, 0);
    run_instr(KSubu, 1'b0, 0);
    run_instr(KOri, 1'b0, 0);
    run_instr(KLui, 1'b0, 0);
    run_instr(KJ, 1'b0, 0);
    run_instr(KJr, 1'b0, 0);
    run_instr(KNop, 1'b0, 0);

    for (int i = 0; i < 80; i++) begin
      run_instr(kind_e'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
    end

    // Abort a lw while it waits in MEM.
    opcode = 6'h23;
    funct = 6'h00;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reg_we_before_abort", reg_we, 0);
    end
    #1 rst_n = 1'b0;
    #1;
    check("abort_strobes", {ir_we, pc_we, reg_we, mem_we, illegal}, 0);
    check("abort_retired", retired, 0);
    model_ret = '0;
    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    check("ir_we_after_abort", ir_we, 1);
    check("retired_after_abort", retired, 0);

    for (int i = 0; i < 16; i++) run_instr(KNop, 1'b0, 0);
    check("retired_wrap", retired, 0);
    check("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

- Multi-cycle control FSM for the MIPS CPU.
- Takes the latched instruction's opcode/funct and the ALU `Zero` flag.
- Drives `ALUOp`, operand selects, register/memory write strobes and next-PC selection, one datapath phase per cycle.
- Sits opposite the ALU on the ALUOp/Zero interface and replaces the single-cycle combinational controller.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - reset  in  1  asynchronous active-low reset
- Instruction and status inputs:
  - opcode  in  6  instr[31:26] from datapath IR (stable after FETCH)
  - funct  in  6  instr[5:0] from datapath IR
  - alu_zero  in  1  ALU Zero flag
  - mem_ready  in  1  data memory completes access this cycle
- Strobes and selects:
  - ir_we  out  1  latch instruction into IR
  - pc_we  out  1  update PC from NPC
  - npc_sel  out  2  0 PC+4, 1 branch, 2 jump, 3 jr (rs)
  - reg_we  out  1  GRF write
  - reg_dst  out  2  0 rt, 1 rd, 2 $31
  - mem_to_reg  out  2  0 ALU result, 1 memory data, 2 PC+4
  - mem_we  out  1  data memory write
  - alu_op  out  3  0 add, 1 sub, 2 and, 3 or
  - alu_src  out  1  0 rt data, 1 extended immediate
  - ext_op  out  2  0 zero-extend, 1 sign-extend, 2 imm<<16
- Status outputs:
  - illegal  out  1  undecoded instruction seen in DECODE
  - retired  out  CNT_W  count of completed instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. Stored state is binary-encoded.
- All strobes are combinational from state plus decoded class. Selects are decoded from opcode/funct.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop (all-zero word). Anything else is illegal.
- FETCH: ir_we=1 -> DECODE.
- DECODE, by instruction:
  - j: pc_we=1, npc_sel=2 -> FETCH.
  - jal: additionally reg_we=1, reg_dst=2, mem_to_reg=2 -> FETCH.
  - jr: pc_we=1, npc_sel=3 -> FETCH.
  - nop: pc_we=1, npc_sel=0 -> FETCH.
  - illegal: illegal=1, pc_we=1, npc_sel=0 (executed as nop) -> FETCH.
  - otherwise -> EXEC.
- EXEC:
  - addu: alu_op=0, alu_src=0.
  - subu: alu_op=1, alu_src=0.
  - ori: alu_op=3, alu_src=1, ext_op=0.
  - lui: alu_op=3, alu_src=1, ext_op=2 (rs is $0).
  - lw/sw: alu_op=0, alu_src=1, ext_op=1 -> MEM.
  - beq: alu_op=1, alu_src=0, pc_we=1, npc_sel = alu_zero ? 1 : 0 -> FETCH.
  - R-type/ori/lui -> WB.
- MEM:
  - Stays in MEM while mem_ready=0.
  - sw: mem_we=1 every MEM cycle. When mem_ready=1, also pc_we=1, npc_sel=0 -> FETCH.
  - lw: when mem_ready=1 -> WB.
- WB:
  - reg_we=1, pc_we=1, npc_sel=0 -> FETCH.
  - Selects: addu/subu reg_dst=1, mem_to_reg=0. ori/lui reg_dst=0, mem_to_reg=0. lw reg_dst=0, mem_to_reg=1.
- alu_op, alu_src and ext_op stay held from EXEC through MEM/WB so the datapath address/result stays valid.
- retired: increments by 1 in every cycle with pc_we=1, illegal included. Wraps from 2^CNT_W-1 to 0.

## Timing
- Reset low: state=FETCH, retired=0. ir_we, pc_we, reg_we, mem_we, illegal are forced 0 while reset is low. Selects are don't-care.
- First cycle after reset release: FETCH with ir_we=1.
- Cycles per instruction with mem_ready tied 1:
  - j/jal/jr/nop/illegal: 2
  - beq: 3
  - addu/subu/ori/lui: 4
  - sw: 4
  - lw: 5
- Each mem_ready=0 cycle in MEM adds one cycle.
- pc_we is asserted exactly once per instruction, in its last cycle. reg_we and mem_we are never asserted in the same cycle.
- Reset asserted mid-instruction: outputs drop immediately (asynchronously). No write completes after reset falls. Restart is at FETCH.

## Structure
- Package mc_pkg holds:
  - opcode/funct constants (SPECIAL=000000, ORI=001101, LUI=001111, LW=100011, SW=101011, BEQ=000100, J=000010, JAL=000011; ADDU=100001, SUBU=100011, JR=001000)
  - ALUOp, npc_sel, reg_dst, mem_to_reg and ext_op encodings
  - the state enum
- One sub-module, mc_decoder: combinational opcode/funct -> one-hot instruction class plus illegal. The FSM in mc_controller consumes that class.

## Test plan
1. Reset held low 3 cycles, released:
   - all strobes 0 during reset, retired=0
   - cycle 1 after release: ir_we=1, state FETCH
2. addu (op 0, funct 0x21):
   - EXEC shows alu_op=0, alu_src=0
   - WB shows reg_we=1, reg_dst=1, pc_we=1
   - retired +1 after 4 cycles
3. beq:
   - alu_zero=1 -> EXEC pc_we=1, npc_sel=1
   - repeat with alu_zero=0 -> npc_sel=0
   - 3 cycles each
4. lw with mem_ready low for 2 MEM cycles then high:
   - stays in MEM for 3 cycles
   - WB reg_we=1, mem_to_reg=1
   - total 7 cycles
   - sw under the same stimulus: mem_we=1 for all 3 MEM cycles, pc_we only on the last
5. jal:
   - DECODE reg_we=1, reg_dst=2, mem_to_reg=2, pc_we=1, npc_sel=2
   - opcode 0x3F: illegal=1, pc_we=1, npc_sel=0
6. Reset pulled low during lw MEM:
   - reg_we never asserts
   - after release FETCH and retired=0
   - counter wrap: with CNT_W=4, 16 nops return retired to 0
